// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension multiply/divide unit.
package muldiv_pkg;

  // M-extension funct7 value, consumed by the control decoder.
  localparam logic [6:0] MulDivFunct7 = 7'b0000001;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return (op == OpDiv) || (op == OpDivu) || (op == OpRem) || (op == OpRemu);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared iterative datapath: restoring radix-2 divide or shift-add multiply,
// one step per cycle over a (2*XLEN)-bit accumulator.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              is_div,
  input  logic              busy,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic              done,
  output logic [2*XLEN-1:0] acc_nxt
);

  localparam int unsigned CntW = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              is_div_q;
  logic [CntW-1:0]   cnt_q;

  logic [XLEN:0]     part;
  logic [XLEN:0]     diff;
  logic [XLEN:0]     sum;

  // Shifted partial remainder including the bit that carried out of the top.
  assign part = acc_q[2*XLEN-1:XLEN-1];
  assign diff = part - {1'b0, b_q};
  assign sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);

  assign done = busy && (cnt_q == '0);

  // One iteration of the selected algorithm.
  always_comb begin
    acc_nxt = acc_q;
    if (is_div_q) begin
      if (!diff[XLEN]) begin
        acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {sum, acc_q[XLEN-1:1]};
    end
  end

  // Accumulator, operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
    end else if (start) begin
      acc_q    <= {{XLEN{1'b0}}, mag_a};
      b_q      <= mag_b;
      is_div_q <= is_div;
      cnt_q    <= CntW'(XLEN - 1);
    end else if (busy) begin
      acc_q <= acc_nxt;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M iterative multiply/divide execute unit.
// Build option: MULDIV_FAST_MUL_EN gives single-cycle multiplies; otherwise
// multiplies share the iterative shift-add datapath with divide.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op, op_q;
  logic          neg_q, neg;
  logic [XLEN-1:0] result_q;

  logic            signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_by_zero, div_ovf, is_fast, accept, core_done;
  logic [XLEN-1:0] fast_res;
  logic [2*XLEN-1:0] acc_nxt;

  // Applies the sign fix-up and picks the architectural half of the accumulator.
  function automatic logic [XLEN-1:0] fixup(input muldiv_op_e f_op, input logic f_neg,
                                            input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   sel;
    prod = f_neg ? -acc : acc;
    sel  = op_is_rem(f_op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (op_is_div(f_op)) begin
      return f_neg ? -sel : sel;
    end
    return (f_op == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  assign op       = muldiv_op_e'(funct3);
  assign signed_a = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
  assign signed_b = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
  assign sign_a   = signed_a & op_a[XLEN-1];
  assign sign_b   = signed_b & op_b[XLEN-1];
  assign mag_a    = sign_a ? -op_a : op_a;
  assign mag_b    = sign_b ? -op_b : op_b;
  // Remainder follows the dividend; products and quotients follow both signs.
  assign neg      = (op == OpRem) ? sign_a : (sign_a ^ sign_b);

  assign div_by_zero = op_is_div(op) && (op_b == '0);
  assign div_ovf     = ((op == OpDiv) || (op == OpRem)) &&
                       (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign is_fast   = div_by_zero || div_ovf || !op_is_div(op);
`else
  assign is_fast   = div_by_zero || div_ovf;
`endif

  // Result for operations that skip the iterative datapath.
  always_comb begin
    fast_res = '0;
    if (div_by_zero) begin
      fast_res = op_is_rem(op) ? op_a : '1;
    end else if (div_ovf) begin
      fast_res = op_is_rem(op) ? '0 : op_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      fast_res = fixup(op, neg, fast_prod);
    end
`endif
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready && !flush;

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_iter_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .start   (accept && !is_fast),
    .is_div  (op_is_div(op)),
    .busy    (state_q == BUSY),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .done    (core_done),
    .acc_nxt (acc_nxt)
  );

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) state_d = is_fast ? DONE : BUSY;
      end
      BUSY: begin
        if (core_done) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched operation context and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= op;
        neg_q <= neg;
      end
      if (accept && is_fast) begin
        result_q <= fast_res;
      end else if (core_done && !flush) begin
        result_q <= fixup(op_q, neg_q, acc_nxt);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  muldiv_unit #(
    .XLEN (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; return sp[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; return sp[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2]) begin
      if (b == 0) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return MulLat;
  endfunction

  // Issue one operation from a negedge, measure latency, hold the result
  // for 'hold' cycles of backpressure, then complete the handshake.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                        input int hold);
    int   guard;
    int   lat;
    logic ready_in_flight;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard == 100) check_eq({tag, " idle_timeout"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    ready_in_flight = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_in_flight = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " result"}, 64'(result), 64'(exp_res));
    check_eq({tag, " ready_busy"}, 64'(ready_in_flight), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq({tag, " hold_result"}, 64'(result), 64'(exp_res));
      check_eq({tag, " hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({tag, " hold_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    check_eq({tag, " hs_ready"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, " post_hs_ready"}, 64'(in_ready), 64'd1);
    check_eq({tag, " post_hs_valid"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic        seen;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    // Reset values, both while asserted and just after release.
    #3;
    check_eq("rst_ready", 64'(in_ready), 64'd1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", 64'(in_ready), 64'd1);
    check_eq("idle_valid", 64'(out_valid), 64'd0);

    // Directed cases.
    run_op("div_neg7_2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op("rem_neg7_2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op("divu_by0",    3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_by0",    3'd7, 32'd100, 32'd0, 32'h0000_0064, 1, 0);
    run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run_op("mul_m1",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MulLat, 0);
    run_op("mulhu_m1",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MulLat, 0);
    run_op("mulhsu_m1",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 0);
    run_op("mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MulLat, 0);
    run_op("backpressure", 3'd5, 32'd1000, 32'd7, 32'd142, 33, 5);

    // Flush while BUSY with the counter at 20.
    in_valid = 1'b1;
    funct3   = 3'd5;
    op_a     = 32'd1000;
    op_b     = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_ready", 64'(in_ready), 64'd1);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("flush_no_valid", 64'(seen), 64'd0);
    run_op("divu_10_3", 3'd5, 32'd10, 32'd3, 32'd3, 33, 0);

    // Flush together with in_valid in IDLE must not accept.
    flush    = 1'b1;
    in_valid = 1'b1;
    funct3   = 3'd5;
    op_a     = 32'd50;
    op_b     = 32'd5;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_acc_ready", 64'(in_ready), 64'd1);
    check_eq("flush_acc_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq("flush_acc_ready2", 64'(in_ready), 64'd1);

    // Asynchronous reset in the middle of BUSY, away from any clock edge.
    in_valid = 1'b1;
    funct3   = 3'd4;
    op_a     = 32'd12345;
    op_b     = 32'd17;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_busy", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ready", 64'(in_ready), 64'd1);
    check_eq("async_rst_valid", 64'(out_valid), 64'd0);
    check_eq("async_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = rand_opnd();
      rb  = rand_opnd();
      run_op($sformatf("rand%0d_f%0d_%h_%h", n, rf3, ra, rb), rf3, ra, rb,
             ref_model(rf3, ra, rb), ref_lat(rf3, ra, rb), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
